// File: rtl/ysyx_23060184_ifu_if.sv
// Instruction-fetch read channel between the IFU (master) and instruction memory (slave).
// Address and read-data phases each use a valid/ready pair.
interface ysyx_23060184_ifu_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/ysyx_23060184_ifu.sv
// Single-issue instruction fetch unit: one fetch in flight, handshakes to decode,
// then waits for writeback to supply the next PC (with a one-entry early-update buffer).
module ysyx_23060184_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                      clk,
  input  logic                      resetn,
  ysyx_23060184_ifu_if.master       mem,
  output logic [31:0]               inst,
  output logic [31:0]               pc,
  output logic                      Ivalid,
  input  logic                      Dready,
  input  logic [31:0]               next_pc,
  input  logic                      pc_update,
  output logic                      fetch_err,
  output logic [31:0]               inst_cnt
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_DATA    = 3'd2,
    S_HOLD    = 3'd3,
    S_WAIT_PC = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_d, inst_d, cnt_d, pend_pc_q, pend_pc_d, redirect;
  logic              err_d, pend_q, pend_d;
  logic              arvalid_q, rready_q;

  assign mem.araddr  = pc;
  assign mem.arvalid = arvalid_q;
  assign mem.rready  = rready_q;

  // Next-state and datapath update; handshake strobes are registered from state_d.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc;
    inst_d    = inst;
    err_d     = fetch_err;
    cnt_d     = inst_cnt;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    redirect  = next_pc;

    // Early PC updates are parked; the newest one wins.
    if (pc_update && (state_q != S_WAIT_PC)) begin
      pend_d    = 1'b1;
      pend_pc_d = next_pc;
    end

    case (state_q)
      S_IDLE: state_d = S_ADDR;
      S_ADDR: begin
        if (arvalid_q && mem.arready) state_d = S_DATA;
      end
      S_DATA: begin
        if (mem.rvalid) begin
          state_d = S_HOLD;
          if (mem.rresp == 2'b00) begin
            inst_d = mem.rdata;
          end else begin
            inst_d = NOP_INST;
            err_d  = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (Ivalid && Dready) begin
          state_d = S_WAIT_PC;
          cnt_d   = inst_cnt + XLEN'(1);
        end
      end
      S_WAIT_PC: begin
        // A live update outranks the parked one.
        if (pc_update || pend_q) begin
          redirect = pc_update ? next_pc : pend_pc_q;
          pc_d     = redirect;
          pend_d   = 1'b0;
          state_d  = S_ADDR;
          if (redirect[1:0] != 2'b00) err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      pc        <= RESET_PC;
      inst      <= '0;
      inst_cnt  <= '0;
      fetch_err <= 1'b0;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      Ivalid    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc        <= pc_d;
      inst      <= inst_d;
      inst_cnt  <= cnt_d;
      fetch_err <= err_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      arvalid_q <= (state_d == S_ADDR);
      rready_q  <= (state_d == S_DATA);
      Ivalid    <= (state_d == S_HOLD);
    end
  end

endmodule

// File: tb/tb_ysyx_23060184_ifu.sv
// Directed bench for the IFU: fetch flow, stalls, error substitution, PC redirect buffering, reset.
module tb_ysyx_23060184_ifu;

  logic        clk;
  logic        resetn;
  logic [31:0] inst, pc, next_pc, inst_cnt;
  logic        Ivalid, Dready, pc_update, fetch_err;
  int          checks = 0;
  int          errors = 0;
  logic        mon_en = 1'b0;

  ysyx_23060184_ifu_if bus ();

  ysyx_23060184_ifu dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem       (bus),
    .inst      (inst),
    .pc        (pc),
    .Ivalid    (Ivalid),
    .Dready    (Dready),
    .next_pc   (next_pc),
    .pc_update (pc_update),
    .fetch_err (fetch_err),
    .inst_cnt  (inst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake strobes must be mutually exclusive at all times.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if ((32'(bus.arvalid) + 32'(bus.rready) + 32'(Ivalid)) > 32'd1) begin
        errors++;
        $display("FAIL onehot_strobes: arvalid=%b rready=%b Ivalid=%b expected at most one high", bus.arvalid, bus.rready, Ivalid);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Full fetch from WAIT_PC with immediate handshakes; returns what decode saw in HOLD.
  task automatic do_fetch(input logic [31:0] npc, input logic [31:0] data, input logic [1:0] resp,
                          output logic [31:0] o_inst, output logic [31:0] o_pc, output logic o_iv);
    pc_update = 1'b1; next_pc = npc;
    tick(1);
    pc_update = 1'b0; bus.arready = 1'b1;
    tick(1);
    bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = data; bus.rresp = resp;
    tick(1);
    bus.rvalid = 1'b0; bus.rresp = 2'b00;
    o_inst = inst; o_pc = pc; o_iv = Ivalid;
    Dready = 1'b1;
    tick(1);
    Dready = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0; bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
    Dready = 1'b0; pc_update = 1'b0; next_pc = '0;
    tick(2);
    mon_en = 1'b1;
    checks++; if (bus.arvalid !== 1'b0) begin errors++; $display("FAIL rst_arvalid: got %b expected 0", bus.arvalid); end
    checks++; if (bus.rready !== 1'b0) begin errors++; $display("FAIL rst_rready: got %b expected 0", bus.rready); end
    checks++; if (Ivalid !== 1'b0) begin errors++; $display("FAIL rst_Ivalid: got %b expected 0", Ivalid); end
    checks++; if (pc !== 32'h8000_0000) begin errors++; $display("FAIL rst_pc: got %h expected 80000000", pc); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL rst_inst: got %h expected 00000000", inst); end
    checks++; if (inst_cnt !== 32'h0) begin errors++; $display("FAIL rst_cnt: got %0d expected 0", inst_cnt); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", fetch_err); end
  endtask

  task automatic test_basic;
    resetn = 1'b1; bus.arready = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'h0010_0093; bus.rresp = 2'b00; Dready = 1'b1;
    tick(1);
    checks++; if (bus.arvalid !== 1'b1) begin errors++; $display("FAIL basic_arvalid: got %b expected 1", bus.arvalid); end
    checks++; if (bus.araddr !== 32'h8000_0000) begin errors++; $display("FAIL basic_araddr: got %h expected 80000000", bus.araddr); end
    tick(1);
    checks++; if (bus.rready !== 1'b1) begin errors++; $display("FAIL basic_rready: got %b expected 1", bus.rready); end
    tick(1);
    checks++; if (Ivalid !== 1'b1) begin errors++; $display("FAIL basic_Ivalid: got %b expected 1", Ivalid); end
    checks++; if (inst !== 32'h0010_0093) begin errors++; $display("FAIL basic_inst: got %h expected 00100093", inst); end
    checks++; if (pc !== 32'h8000_0000) begin errors++; $display("FAIL basic_pc: got %h expected 80000000", pc); end
    tick(1);
    bus.arready = 1'b0; bus.rvalid = 1'b0; Dready = 1'b0;
    checks++; if (Ivalid !== 1'b0) begin errors++; $display("FAIL basic_Ivalid_drop: got %b expected 0", Ivalid); end
    checks++; if (inst_cnt !== 32'd1) begin errors++; $display("FAIL basic_cnt: got %0d expected 1", inst_cnt); end
    tick(1);
    checks++; if (bus.arvalid !== 1'b0) begin errors++; $display("FAIL basic_wait_idle: arvalid got %b expected 0", bus.arvalid); end
  endtask

  task automatic test_arready_stall;
    pc_update = 1'b1; next_pc = 32'h8000_0004;
    tick(1);
    pc_update = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.arvalid !== 1'b1) begin errors++; $display("FAIL stall_arvalid[%0d]: got %b expected 1", i, bus.arvalid); end
      checks++; if (bus.araddr !== 32'h8000_0004) begin errors++; $display("FAIL stall_araddr[%0d]: got %h expected 80000004", i, bus.araddr); end
      checks++; if (bus.rready !== 1'b0) begin errors++; $display("FAIL stall_rready[%0d]: got %b expected 0", i, bus.rready); end
      if (i < 2) tick(1);
    end
    bus.arready = 1'b1;
    tick(1);
    bus.arready = 1'b0;
    checks++; if (bus.rready !== 1'b1) begin errors++; $display("FAIL stall_data_entry: rready got %b expected 1", bus.rready); end
    bus.rvalid = 1'b1; bus.rdata = 32'h0020_0113;
    tick(1);
    bus.rvalid = 1'b0;
    checks++; if (inst !== 32'h0020_0113) begin errors++; $display("FAIL stall_inst: got %h expected 00200113", inst); end
    checks++; if (pc !== 32'h8000_0004) begin errors++; $display("FAIL stall_pc: got %h expected 80000004", pc); end
    Dready = 1'b1;
    tick(1);
    Dready = 1'b0;
    checks++; if (inst_cnt !== 32'd2) begin errors++; $display("FAIL stall_cnt: got %0d expected 2", inst_cnt); end
  endtask

  task automatic test_fetch_error;
    logic [31:0] oi, op; logic ov;
    do_fetch(32'h8000_0008, 32'hDEAD_BEEF, 2'b10, oi, op, ov);
    checks++; if (oi !== 32'h0000_0013) begin errors++; $display("FAIL err_inst: got %h expected 00000013", oi); end
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL err_Ivalid: got %b expected 1", ov); end
    checks++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL err_flag: got %b expected 1", fetch_err); end
    do_fetch(32'h8000_000C, 32'h0030_0193, 2'b00, oi, op, ov);
    checks++; if (oi !== 32'h0030_0193) begin errors++; $display("FAIL err_good1_inst: got %h expected 00300193", oi); end
    do_fetch(32'h8000_0010, 32'h0040_0213, 2'b00, oi, op, ov);
    checks++; if (op !== 32'h8000_0010) begin errors++; $display("FAIL err_good2_pc: got %h expected 80000010", op); end
    checks++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", fetch_err); end
    checks++; if (inst_cnt !== 32'd5) begin errors++; $display("FAIL err_cnt: got %0d expected 5", inst_cnt); end
  endtask

  task automatic test_decode_stall;
    pc_update = 1'b1; next_pc = 32'h8000_0020;
    tick(1);
    pc_update = 1'b0; bus.arready = 1'b1;
    tick(1);
    bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h0050_0293;
    tick(1);
    bus.rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (Ivalid !== 1'b1) begin errors++; $display("FAIL hold_Ivalid[%0d]: got %b expected 1", i, Ivalid); end
      checks++; if (inst !== 32'h0050_0293) begin errors++; $display("FAIL hold_inst[%0d]: got %h expected 00500293", i, inst); end
      checks++; if (pc !== 32'h8000_0020) begin errors++; $display("FAIL hold_pc[%0d]: got %h expected 80000020", i, pc); end
      checks++; if (inst_cnt !== 32'd5) begin errors++; $display("FAIL hold_cnt[%0d]: got %0d expected 5", i, inst_cnt); end
      tick(1);
    end
    Dready = 1'b1;
    tick(1);
    Dready = 1'b0;
    checks++; if (Ivalid !== 1'b0) begin errors++; $display("FAIL hold_release: Ivalid got %b expected 0", Ivalid); end
    checks++; if (inst_cnt !== 32'd6) begin errors++; $display("FAIL hold_cnt_once: got %0d expected 6", inst_cnt); end
    tick(1);
    checks++; if (inst_cnt !== 32'd6) begin errors++; $display("FAIL hold_cnt_stable: got %0d expected 6", inst_cnt); end
  endtask

  task automatic test_pending_redirect;
    pc_update = 1'b1; next_pc = 32'h8000_0030;
    tick(1);
    pc_update = 1'b0; bus.arready = 1'b1;
    tick(1);
    bus.arready = 1'b0; pc_update = 1'b1; next_pc = 32'h8000_0010;
    tick(1);
    pc_update = 1'b0; next_pc = 32'h1234_5678;
    checks++; if (bus.rready !== 1'b1) begin errors++; $display("FAIL pend_in_data: rready got %b expected 1", bus.rready); end
    bus.rvalid = 1'b1; bus.rdata = 32'h0060_0313;
    tick(1);
    bus.rvalid = 1'b0;
    checks++; if (pc !== 32'h8000_0030) begin errors++; $display("FAIL pend_hold_pc: got %h expected 80000030", pc); end
    Dready = 1'b1;
    tick(1);
    Dready = 1'b0;
    tick(1);
    checks++; if (bus.arvalid !== 1'b1) begin errors++; $display("FAIL pend_arvalid: got %b expected 1", bus.arvalid); end
    checks++; if (bus.araddr !== 32'h8000_0010) begin errors++; $display("FAIL pend_araddr: got %h expected 80000010", bus.araddr); end
    bus.arready = 1'b1;
    tick(1);
    bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h0070_0393;
    tick(1);
    bus.rvalid = 1'b0;
    checks++; if (inst !== 32'h0070_0393) begin errors++; $display("FAIL pend_inst: got %h expected 00700393", inst); end
    Dready = 1'b1;
    tick(1);
    Dready = 1'b0;
    tick(2);
    checks++; if (bus.arvalid !== 1'b0) begin errors++; $display("FAIL pend_cleared: arvalid got %b expected 0", bus.arvalid); end
    checks++; if (inst_cnt !== 32'd8) begin errors++; $display("FAIL pend_cnt: got %0d expected 8", inst_cnt); end
  endtask

  task automatic test_reset_mid;
    pc_update = 1'b1; next_pc = 32'h8000_0040;
    tick(1);
    pc_update = 1'b0; bus.arready = 1'b1;
    tick(1);
    bus.arready = 1'b0;
    checks++; if (bus.rready !== 1'b1) begin errors++; $display("FAIL mid_in_data: rready got %b expected 1", bus.rready); end
    resetn = 1'b0;
    tick(1);
    checks++; if (bus.rready !== 1'b0) begin errors++; $display("FAIL mid_rready: got %b expected 0", bus.rready); end
    checks++; if (inst_cnt !== 32'd0) begin errors++; $display("FAIL mid_cnt: got %0d expected 0", inst_cnt); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b expected 0", fetch_err); end
    checks++; if (pc !== 32'h8000_0000) begin errors++; $display("FAIL mid_pc: got %h expected 80000000", pc); end
    resetn = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'hBADB_ADBA;
    tick(1);
    checks++; if (bus.arvalid !== 1'b1) begin errors++; $display("FAIL mid_restart_arvalid: got %b expected 1", bus.arvalid); end
    checks++; if (bus.araddr !== 32'h8000_0000) begin errors++; $display("FAIL mid_restart_araddr: got %h expected 80000000", bus.araddr); end
    tick(1);
    checks++; if (bus.rready !== 1'b0) begin errors++; $display("FAIL mid_stale_rvalid: rready got %b expected 0", bus.rready); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL mid_stale_inst: got %h expected 00000000", inst); end
    bus.rvalid = 1'b0; bus.arready = 1'b1;
    tick(1);
    bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h0080_0413;
    tick(1);
    bus.rvalid = 1'b0;
    checks++; if (inst !== 32'h0080_0413) begin errors++; $display("FAIL mid_inst: got %h expected 00800413", inst); end
    Dready = 1'b1;
    tick(1);
    Dready = 1'b0;
    checks++; if (inst_cnt !== 32'd1) begin errors++; $display("FAIL mid_cnt_after: got %0d expected 1", inst_cnt); end
  endtask

  task automatic test_misaligned;
    logic [31:0] oi, op; logic ov;
    pc_update = 1'b1; next_pc = 32'h8000_0102;
    tick(1);
    pc_update = 1'b0;
    checks++; if (bus.araddr !== 32'h8000_0102) begin errors++; $display("FAIL mis_araddr: got %h expected 80000102", bus.araddr); end
    checks++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL mis_err: got %b expected 1", fetch_err); end
    bus.arready = 1'b1;
    tick(1);
    bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h0090_0493;
    tick(1);
    bus.rvalid = 1'b0; Dready = 1'b1;
    tick(1);
    Dready = 1'b0;
    do_fetch(32'h8000_0200, 32'h00A0_0513, 2'b00, oi, op, ov);
    checks++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL mis_sticky: got %b expected 1", fetch_err); end
  endtask

  task automatic test_priority;
    pc_update = 1'b1; next_pc = 32'h8000_0300;
    tick(1);
    pc_update = 1'b1; next_pc = 32'h8000_0200; bus.arready = 1'b1;
    tick(1);
    pc_update = 1'b0; bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h00B0_0593;
    tick(1);
    bus.rvalid = 1'b0; Dready = 1'b1; pc_update = 1'b1; next_pc = 32'h8000_0400;
    tick(1);
    Dready = 1'b0; pc_update = 1'b0;
    checks++; if (pc !== 32'h8000_0300) begin errors++; $display("FAIL prio_wait_pc: got %h expected 80000300", pc); end
    tick(1);
    checks++; if (bus.araddr !== 32'h8000_0400) begin errors++; $display("FAIL prio_araddr: got %h expected 80000400", bus.araddr); end
    checks++; if (bus.arvalid !== 1'b1) begin errors++; $display("FAIL prio_arvalid: got %b expected 1", bus.arvalid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arready_stall();
    test_fetch_error();
    test_decode_stall();
    test_pending_redirect();
    test_reset_mid();
    test_misaligned();
    test_priority();
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
